muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) issued from the EX stage.
- Accepts an M-type instruction together with the already-forwarded operands, and asserts a stall that freezes IF/ID/EX and bubbles EX/MEM while it iterates.
- Presents a single-cycle result to the EX output mux when finished.
- Sits beside the ALU. It is driven by the same forwarding-mux outputs; hazard logic ORs its stall into the pipeline stall.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a valid M instruction (FUNCT7_EX = 0000001, R-type opcode).
- flush  input  1  EX instruction is squashed (taken branch); aborts the operation.
- funct3  input  3  M-operation select, RISC-V encoding.
- op_a  input  XLEN  rs1 value after forwarding.
- op_b  input  XLEN  rs2 value after forwarding.
- rd_in  input  5  destination register of the EX instruction.
- stall  output  1  freeze IF/ID/EX and insert a bubble into MEM.
- busy  output  1  sequencer not in IDLE.
- result_valid  output  1  result is valid this cycle; the EX result mux selects it.
- result  output  XLEN  M-operation result.
- rd_out  output  5  destination tag of the result.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE. The following outputs are all 0: stall, busy, result_valid, result, rd_out. Internal registers (accumulator, remainder, operands, counter) are also cleared. Reset mid-operation discards all work.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - stall = start & ~flush (combinational), so the instruction is held in EX from its first cycle.
  - On start & ~flush, latch operand magnitudes, sign-fix flags, funct3 and rd_in; load counter = XLEN.
  - funct3[2] = 0 → MUL.
  - funct3[2] = 1 and op_b = 0 → DONE. DIV/DIVU result = all ones; REM/REMU result = op_a.
  - funct3[2] = 1, signed op (DIV/REM), op_a = 100…0 and op_b = all ones → DONE. DIV result = op_a; REM result = 0.
  - Otherwise (funct3[2] = 1) → DIV.
- MUL:
  - Radix-2 shift-add over magnitudes, 2*XLEN-bit product, one bit per cycle. Counter decrements each cycle; at 0 → DONE.
  - Signedness: MULH both operands signed; MULHSU only op_a signed; MULHU none. Negate the product if the sign flags differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV:
  - Restoring division over magnitudes, one quotient bit per cycle. Counter decrements; at 0 → DONE.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of op_a (REM only).
- stall stays 1 throughout MUL and DIV.
- DONE:
  - stall = 0, result_valid = 1, busy = 1, result and rd_out registered and stable.
  - Pipeline advances this cycle; next state is IDLE unconditionally.
  - start is ignored in DONE, so the same instruction never re-triggers.
- Latency:
  - Iterative ops: result_valid XLEN+1 cycles after start is first sampled; stall is high for XLEN+1 cycles.
  - Special cases (divide by zero, signed overflow): result_valid 1 cycle after start; stall is high for 1 cycle.
- Back-to-back M instructions: the second instruction's start is seen in the IDLE cycle that follows DONE. No bubble is added beyond that IDLE cycle.
- flush:
  - In IDLE: blocks the start.
  - In MUL/DIV: next state is IDLE, stall drops the following cycle, result_valid is never asserted.
  - In DONE: has no effect (the instruction already completed).
- busy = (state ≠ IDLE). result_valid is high only in DONE.

Test Plan:
1. Reset asserted mid-DIV (cycle 10 of 32) → all outputs 0 immediately (asynchronous); after release, state IDLE and stall = 0 while start = 0.
2. MUL 0x0000_0007 × 0xFFFF_FFFD (−3), rd = 5 → stall high 33 cycles, then result_valid for 1 cycle with result = 0xFFFF_FFEB and rd_out = 5. The same operands with MULHU give result = 0x0000_0006; with MULH, 0xFFFF_FFFF.
3. DIV −7 / 2 → result = 0xFFFF_FFFD (−3). REM −7 / 2 → 0xFFFF_FFFF (−1). DIVU 0xFFFF_FFF9 / 2 → 0x7FFF_FFFC. Each completes after 33 cycles.
4. DIVU 123 / 0 → result_valid after 1 cycle, result = 0xFFFF_FFFF. REM 123 / 0 → 123. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 after 1 cycle; REM with the same operands → 0.
5. flush pulsed at cycle 5 of a MUL → busy = 0 on the next cycle, stall = 0, result_valid never asserted. A new start two cycles later completes with the correct result.
6. Two back-to-back MULs (start held high, operands changed after DONE) → two distinct result_valid pulses, 34 cycles apart. The first instruction is not re-executed.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the ALU: stalls the pipeline while it
// iterates one bit per cycle and presents a one-cycle result to the EX result mux.
//
// state  | meaning
// IDLE   | waiting for an M instruction in EX
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | result valid for one cycle, pipeline advances
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mag_q, mag_d;
  logic [1:0]        op_sel_q, op_sel_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  logic              signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // MUL (000) uses unsigned magnitudes: the low half is sign-independent
  assign signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = signed_a & op_a[XLEN-1];
  assign b_neg    = signed_b & op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;

  // acc holds {partial product high, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

  // acc holds {partial remainder, dividend bits shifting into quotient}
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign quo_fix   = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fix   = rem_neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    op_sel_d  = op_sel_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    rd_d      = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_sel_d  = funct3[1:0];
          rd_d      = rd_in;
          cnt_d     = CNT_W'(XLEN);
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          if (!funct3[2]) begin
            mag_d   = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = S_MUL;
          end else if (op_b == '0) begin
            result_d = funct3[1] ? op_a : '1;
            state_d  = S_DONE;
          end else if (!funct3[0] && (op_a == INT_MIN) && (op_b == '1)) begin
            result_d = funct3[1] ? '0 : op_a;
            state_d  = S_DONE;
          end else begin
            mag_d   = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = (op_sel_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = op_sel_q[1] ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      op_sel_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      op_sel_q  <= op_sel_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
    end
  end

  // reset gates the combinational start path so stall is 0 throughout reset
  assign stall        = ((state_q == S_IDLE) && start && !flush && reset) ||
                        (state_q == S_MUL) || (state_q == S_DIV);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign rd_out       = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues hand-computed results with
// their expected arrival cycle; a monitor pops and compares on every result_valid.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall), .busy(busy),
    .result_valid(result_valid), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got result %h rd %0d, expected no result", result, rd_out);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("rd_out", 32'(rd_out), 32'(e.rd));
          check("valid_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input bit expect_res);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    if (expect_res) sb.push_back('{exp, rd, cyc + lat});
    #1 check("stall_on_issue", 32'(stall), 32'd1);
  endtask

  task automatic wait_done(input int lat, input int n0, input bit drop_start);
    int n;
    bit got;
    n = n0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall === 1'b1) n++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no result_valid in 200 cycles, expected one");
      start = 1'b0;
    end else begin
      check("stall_cycles", n, lat);
      check("stall_in_done", 32'(stall), 32'd0);
      check("busy_in_done", 32'(busy), 32'd1);
      if (drop_start) start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    issue(f, a, b, rd, exp, lat, 1'b1);
    wait_done(lat, 1, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op(F_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  32'h0000_0006, 33);
    run_op(F_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 5'd7,  32'hFFFF_FFFF, 33);
    run_op(F_MULHSU, 32'h0000_0007, 32'hFFFF_FFFD, 5'd8,  32'h0000_0006, 33);
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, 33);
    run_op(F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 33);
    run_op(F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 33);
    run_op(F_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'h7FFF_FFFC, 33);
    run_op(F_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         33);
    run_op(F_DIV,    32'h8000_0000, 32'h0000_0002, 5'd14, 32'hC000_0000, 33);
    run_op(F_DIVU,   32'd123,       32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run_op(F_REM,    32'd123,       32'd0,         5'd16, 32'd123,       1);
    run_op(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    run_op(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1);

    // reset ten cycles into a divide
    issue(F_DIV, 32'd1000, 32'd3, 5'd19, 32'd0, 33, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_stall", 32'(stall), 32'd0);

    // flush five cycles into a multiply
    issue(F_MUL, 32'd9, 32'd9, 5'd20, 32'd0, 33, 1'b0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    run_op(F_MUL, 32'd6, 32'd7, 5'd21, 32'd42, 33);

    // back-to-back with start held through DONE
    issue(F_MUL, 32'd3, 32'd5, 5'd1, 32'd15, 33, 1'b1);
    wait_done(33, 1, 1'b0);
    op_a = 32'd100; op_b = 32'd200; rd_in = 5'd2;
    sb.push_back('{32'd20000, 5'd2, cyc + 34});
    wait_done(33, 0, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
